ddr3_avl_arbiter: RTL and testbench

//  Shares the single DDR3 Avalon-MM port between the display read engine and the write engine.

---
 rtl/ddr3_avl_arbiter_pkg.sv | 15 +
 rtl/ddr3_avl_arbiter_if.sv | 54 +++++
 rtl/ddr3_avl_arbiter.sv | 128 ++++++++++++
 tb/tb_ddr3_avl_arbiter.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_avl_arbiter_pkg.sv
// Shared definitions for the DDR3 Avalon-MM arbiter: state encoding and default widths.
package ddr3_avl_arbiter_pkg;

    localparam int ADDR_W_DEF     = 26;
    localparam int DATA_W_DEF     = 128;
    localparam int SIZE_W_DEF     = 3;
    localparam int MAX_RD_RUN_DEF = 16;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_RD   = 2'd1,
        ARB_WR   = 2'd2
    } arb_state_e;

endpackage

// File: rtl/ddr3_avl_arbiter_if.sv
// Bundle of read-engine, write-engine and controller-side signals around the arbiter.
interface ddr3_avl_arbiter_if
    import ddr3_avl_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int SIZE_W = SIZE_W_DEF
) ();

    // Handshakes: a command/beat transfers in a cycle where its req and the matching ready
    // are both high; req and payload are held stable by the source until that cycle.
    logic              rd_req;
    logic              rd_burstbegin;
    logic [SIZE_W-1:0] rd_size;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ready;

    logic              wr_req;
    logic              wr_burstbegin;
    logic [SIZE_W-1:0] wr_size;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;

    logic              avl_ready;
    logic              avl_read_req;
    logic              avl_write_req;
    logic              avl_burstbegin;
    logic [SIZE_W-1:0] avl_size;
    logic [ADDR_W-1:0] avl_addr;
    logic [DATA_W-1:0] avl_wr_data;

    logic              grant_rd;
    logic              grant_wr;

    modport slave (
        input  rd_req, rd_burstbegin, rd_size, rd_addr,
        input  wr_req, wr_burstbegin, wr_size, wr_addr, wr_data,
        input  avl_ready,
        output rd_ready, wr_ready,
        output avl_read_req, avl_write_req, avl_burstbegin, avl_size, avl_addr, avl_wr_data,
        output grant_rd, grant_wr
    );

    modport master (
        output rd_req, rd_burstbegin, rd_size, rd_addr,
        output wr_req, wr_burstbegin, wr_size, wr_addr, wr_data,
        output avl_ready,
        input  rd_ready, wr_ready,
        input  avl_read_req, avl_write_req, avl_burstbegin, avl_size, avl_addr, avl_wr_data,
        input  grant_rd, grant_wr
    );

endinterface

// File: rtl/ddr3_avl_arbiter.sv
// Registered-grant arbiter sharing one DDR3 Avalon-MM port between the read and write engines.
// Reads win by default; a bounded read run lets a pending write burst through, never split.
module ddr3_avl_arbiter
    import ddr3_avl_arbiter_pkg::*;
#(
    parameter int SIZE_W     = SIZE_W_DEF,
    parameter int MAX_RD_RUN = MAX_RD_RUN_DEF
) (
    input  logic              ddr3_clk,
    input  logic              reset_n,
    ddr3_avl_arbiter_if.slave bus,
    output arb_state_e        state_o
);

    localparam int RUN_W = $clog2(MAX_RD_RUN + 1);

    arb_state_e        state_q, state_d;
    logic [SIZE_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [RUN_W-1:0]  rd_run_q, rd_run_d;

    logic              rd_acc;
    logic              wr_acc;
    logic              wr_start;
    logic              wr_end;
    logic              run_limit;
    logic [SIZE_W-1:0] first_left;

    always_ff @(posedge ddr3_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ARB_IDLE;
            beat_cnt_q <= '0;
            rd_run_q   <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            rd_run_q   <= rd_run_d;
        end
    end

    always_comb begin
        rd_acc     = (state_q == ARB_RD) && bus.rd_req && bus.avl_ready;
        wr_acc     = (state_q == ARB_WR) && bus.wr_req && bus.avl_ready;
        wr_start   = bus.wr_req && bus.wr_burstbegin;
        run_limit  = (rd_run_q >= RUN_W'(MAX_RD_RUN));
        // Size 0 is treated as a single beat, so nothing remains after the first one.
        first_left = (bus.wr_size == '0) ? '0 : bus.wr_size - SIZE_W'(1);

        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        rd_run_d   = rd_run_q;
        wr_end     = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (bus.rd_req && !(wr_start && run_limit)) begin
                    state_d = ARB_RD;
                end else if (wr_start) begin
                    state_d = ARB_WR;
                end
            end
            ARB_RD: begin
                if (rd_acc) begin
                    if (bus.wr_req && (rd_run_q >= RUN_W'(MAX_RD_RUN - 1))) begin
                        state_d = ARB_IDLE;
                    end
                end else if (!bus.rd_req) begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_WR: begin
                if (wr_acc) begin
                    if (bus.wr_burstbegin) begin
                        beat_cnt_d = first_left;
                        wr_end     = (first_left == '0);
                    end else begin
                        wr_end     = (beat_cnt_q <= SIZE_W'(1));
                        beat_cnt_d = wr_end ? '0 : beat_cnt_q - SIZE_W'(1);
                    end
                    if (wr_end) begin
                        state_d = ARB_IDLE;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase

        if (!bus.wr_req || wr_end) begin
            rd_run_d = '0;
        end else if (rd_acc && !run_limit) begin
            rd_run_d = rd_run_q + RUN_W'(1);
        end
    end

    // Outputs depend on the registered state plus the granted engine's own signals only.
    always_comb begin
        bus.rd_ready       = 1'b0;
        bus.wr_ready       = 1'b0;
        bus.avl_read_req   = 1'b0;
        bus.avl_write_req  = 1'b0;
        bus.avl_burstbegin = 1'b0;
        bus.avl_size       = '0;
        bus.avl_addr       = '0;
        bus.avl_wr_data    = '0;
        case (state_q)
            ARB_RD: begin
                bus.rd_ready       = bus.rd_req && bus.avl_ready;
                bus.avl_read_req   = bus.rd_req;
                bus.avl_burstbegin = bus.rd_burstbegin;
                bus.avl_size       = bus.rd_size;
                bus.avl_addr       = bus.rd_addr;
            end
            ARB_WR: begin
                bus.wr_ready       = bus.wr_req && bus.avl_ready;
                bus.avl_write_req  = bus.wr_req;
                bus.avl_burstbegin = bus.wr_burstbegin;
                bus.avl_size       = bus.wr_size;
                bus.avl_addr       = bus.wr_addr;
                bus.avl_wr_data    = bus.wr_data;
            end
            default: ;
        endcase
        bus.grant_rd = (state_q == ARB_RD);
        bus.grant_wr = (state_q == ARB_WR);
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_ddr3_avl_arbiter.sv
// Self-checking bench for ddr3_avl_arbiter: vector table, hand-written burst sequences and
// a scoreboard of expected controller-side commands.
module tb_ddr3_avl_arbiter;
    import ddr3_avl_arbiter_pkg::*;

    localparam int AW = 26;
    localparam int DW = 128;
    localparam int SW = 4;
    localparam int EW = 1 + AW + DW;
    localparam int NV = 21;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ddr3_avl_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .SIZE_W(SW)) bus ();
    arb_state_e state;

    ddr3_avl_arbiter #(.SIZE_W(SW), .MAX_RD_RUN(16)) dut (
        .ddr3_clk (clk),
        .reset_n  (rst_n),
        .bus      (bus.slave),
        .state_o  (state)
    );

    typedef struct packed {
        logic          rr;
        logic          rbb;
        logic [SW-1:0] rsz;
        logic [AW-1:0] ra;
        logic          wr;
        logic          wbb;
        logic [SW-1:0] wsz;
        logic [AW-1:0] wa;
        logic [7:0]    wd;
        logic          ar;
        logic          e_rrdy;
        logic          e_wrdy;
        logic          e_rreq;
        logic          e_wreq;
        logic          e_grd;
        logic          e_gwr;
        logic [AW-1:0] e_addr;
        logic [SW-1:0] e_size;
    } vec_t;

    vec_t vt [NV];

    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_rd_q[$];
    logic [EW-1:0] exp_wr_q[$];
    logic [EW-1:0] mon_e;
    logic [EW-1:0] drop_e;

    int   rk, wk, cyc, k, stall, w0;
    logic r_acc, w_acc;
    bit   saw_idle;

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [EW-1:0] mk(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        return {w, a, d};
    endfunction

    // Scoreboard: every command the controller accepts must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && bus.avl_ready && bus.avl_read_req) begin
            if (exp_rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_rd: unexpected read accepted, addr %0h", bus.avl_addr);
            end else begin
                mon_e = exp_rd_q.pop_front();
                chk("sb_rd_addr", bus.avl_addr, mon_e[DW+AW-1:DW]);
            end
        end
        if (rst_n && bus.avl_ready && bus.avl_write_req) begin
            if (exp_wr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_wr: unexpected write accepted, addr %0h", bus.avl_addr);
            end else begin
                mon_e = exp_wr_q.pop_front();
                chk("sb_wr_addr", bus.avl_addr, mon_e[DW+AW-1:DW]);
                chk("sb_wr_data", bus.avl_wr_data, mon_e[DW-1:0]);
            end
        end
    end

    task automatic drive_idle();
        bus.rd_req        = 1'b0;
        bus.rd_burstbegin = 1'b0;
        bus.rd_size       = '0;
        bus.rd_addr       = '0;
        bus.wr_req        = 1'b0;
        bus.wr_burstbegin = 1'b0;
        bus.wr_size       = '0;
        bus.wr_addr       = '0;
        bus.wr_data       = '0;
        bus.avl_ready     = 1'b1;
    endtask

    task automatic apply(input vec_t v);
        bus.rd_req        = v.rr;
        bus.rd_burstbegin = v.rbb;
        bus.rd_size       = v.rsz;
        bus.rd_addr       = v.ra;
        bus.wr_req        = v.wr;
        bus.wr_burstbegin = v.wbb;
        bus.wr_size       = v.wsz;
        bus.wr_addr       = v.wa;
        bus.wr_data       = DW'(v.wd);
        bus.avl_ready     = v.ar;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_wr(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.wr_ready && n < 20) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        if (!bus.wr_ready) begin
            checks++;
            errors++;
            $display("FAIL %s: wr_ready not seen within 20 cycles", name);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{1,1,4,'h100, 0,0,0,'h0,'h00,   1, 0,0,0,0,0,0, 'h0,0};
        vt[1]  = '{1,1,4,'h100, 0,0,0,'h0,'h00,   1, 1,0,1,0,1,0, 'h100,4};
        vt[2]  = '{0,0,0,'h0,   0,0,0,'h0,'h00,   1, 0,0,0,0,1,0, 'h0,0};
        vt[3]  = '{0,0,0,'h0,   0,0,0,'h0,'h00,   1, 0,0,0,0,0,0, 'h0,0};
        vt[4]  = '{0,0,0,'h0,   1,0,2,'h1f0,'h00, 1, 0,0,0,0,0,0, 'h0,0};
        vt[5]  = '{0,0,0,'h0,   1,0,2,'h1f0,'h00, 1, 0,0,0,0,0,0, 'h0,0};
        vt[6]  = '{0,0,0,'h0,   1,1,1,'h200,'haa, 1, 0,0,0,0,0,0, 'h0,0};
        vt[7]  = '{0,0,0,'h0,   1,1,1,'h200,'haa, 1, 0,1,0,1,0,1, 'h200,1};
        vt[8]  = '{0,0,0,'h0,   0,0,0,'h0,'h00,   1, 0,0,0,0,0,0, 'h0,0};
        vt[9]  = '{0,0,0,'h0,   1,1,0,'h300,'hbb, 1, 0,0,0,0,0,0, 'h0,0};
        vt[10] = '{0,0,0,'h0,   1,1,0,'h300,'hbb, 1, 0,1,0,1,0,1, 'h300,0};
        vt[11] = '{0,0,0,'h0,   1,1,2,'h310,'hcc, 1, 0,0,0,0,0,0, 'h0,0};
        vt[12] = '{0,0,0,'h0,   1,1,2,'h310,'hcc, 1, 0,1,0,1,0,1, 'h310,2};
        vt[13] = '{0,0,0,'h0,   1,0,0,'h310,'hcd, 0, 0,0,0,1,0,1, 'h310,0};
        vt[14] = '{0,0,0,'h0,   1,0,0,'h310,'hcd, 1, 0,1,0,1,0,1, 'h310,0};
        vt[15] = '{1,1,2,'h120, 1,1,1,'h400,'hdd, 1, 0,0,0,0,0,0, 'h0,0};
        vt[16] = '{1,1,2,'h120, 1,1,1,'h400,'hdd, 1, 1,0,1,0,1,0, 'h120,2};
        vt[17] = '{0,0,0,'h0,   1,1,1,'h400,'hdd, 1, 0,0,0,0,1,0, 'h0,0};
        vt[18] = '{0,0,0,'h0,   1,1,1,'h400,'hdd, 1, 0,0,0,0,0,0, 'h0,0};
        vt[19] = '{0,0,0,'h0,   1,1,1,'h400,'hdd, 1, 0,1,0,1,0,1, 'h400,1};
        vt[20] = '{0,0,0,'h0,   0,0,0,'h0,'h00,   1, 0,0,0,0,0,0, 'h0,0};

        // Reset held with both engines requesting: everything stays quiet.
        drive_idle();
        bus.rd_req        = 1'b1;
        bus.rd_burstbegin = 1'b1;
        bus.rd_addr       = AW'('h55);
        bus.wr_req        = 1'b1;
        bus.wr_burstbegin = 1'b1;
        bus.wr_size       = SW'(2);
        bus.wr_addr       = AW'('h66);
        rst_n             = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_avl_read_req", bus.avl_read_req, 0);
        chk("rst_avl_write_req", bus.avl_write_req, 0);
        chk("rst_rd_ready", bus.rd_ready, 0);
        chk("rst_wr_ready", bus.wr_ready, 0);
        chk("rst_grant_rd", bus.grant_rd, 0);
        chk("rst_grant_wr", bus.grant_wr, 0);
        chk("rst_avl_addr", bus.avl_addr, 0);
        chk("rst_state", state, ARB_IDLE);
        next_cycle();
        drive_idle();
        rst_n = 1'b1;
        next_cycle();

        for (int i = 0; i < NV; i++) begin
            apply(vt[i]);
            if (vt[i].e_rrdy) exp_rd_q.push_back(mk(1'b0, vt[i].ra, '0));
            if (vt[i].e_wrdy) exp_wr_q.push_back(mk(1'b1, vt[i].wa, DW'(vt[i].wd)));
            @(negedge clk);
            chk($sformatf("v%0d_rd_ready", i), bus.rd_ready, vt[i].e_rrdy);
            chk($sformatf("v%0d_wr_ready", i), bus.wr_ready, vt[i].e_wrdy);
            chk($sformatf("v%0d_avl_read_req", i), bus.avl_read_req, vt[i].e_rreq);
            chk($sformatf("v%0d_avl_write_req", i), bus.avl_write_req, vt[i].e_wreq);
            chk($sformatf("v%0d_grant_rd", i), bus.grant_rd, vt[i].e_grd);
            chk($sformatf("v%0d_grant_wr", i), bus.grant_wr, vt[i].e_gwr);
            chk($sformatf("v%0d_avl_addr", i), bus.avl_addr, vt[i].e_addr);
            chk($sformatf("v%0d_avl_size", i), bus.avl_size, vt[i].e_size);
            next_cycle();
        end
        drive_idle();

        // Write burst of 4 with gaps; a read raised on beat 2 must wait for the burst end.
        w0 = 0;
        for (int b = 0; b < 4; b++) begin
            bus.wr_req        = 1'b1;
            bus.wr_burstbegin = (b == 0);
            bus.wr_size       = (b == 0) ? SW'(4) : SW'(0);
            bus.wr_addr       = AW'('h500);
            bus.wr_data       = DW'('h5000 + b);
            exp_wr_q.push_back(mk(1'b1, AW'('h500), DW'('h5000 + b)));
            if (b == 1) begin
                bus.rd_req        = 1'b1;
                bus.rd_burstbegin = 1'b1;
                bus.rd_size       = SW'(2);
                bus.rd_addr       = AW'('h600);
                exp_rd_q.push_back(mk(1'b0, AW'('h600), '0));
            end
            wait_wr($sformatf("t3_beat%0d", b));
            if (bus.wr_ready) w0++;
            chk($sformatf("t3_b%0d_no_read", b), bus.avl_read_req, 0);
            chk($sformatf("t3_b%0d_grant_wr", b), bus.grant_wr, 1);
            next_cycle();
            if (b < 3) begin
                bus.wr_req = 1'b0;
                @(negedge clk);
                chk($sformatf("t3_gap%0d_grant_wr", b), bus.grant_wr, 1);
                chk($sformatf("t3_gap%0d_no_read", b), bus.avl_read_req, 0);
                next_cycle();
            end
        end
        bus.wr_req        = 1'b0;
        bus.wr_burstbegin = 1'b0;
        @(negedge clk);
        chk("t3_beats", w0, 4);
        chk("t3_idle_grant", {bus.grant_rd, bus.grant_wr}, 0);
        chk("t3_idle_no_read", bus.avl_read_req, 0);
        next_cycle();
        @(negedge clk);
        chk("t3_read_after", bus.avl_read_req, 1);
        chk("t3_rd_ready", bus.rd_ready, 1);
        next_cycle();
        bus.rd_req = 1'b0;
        next_cycle();

        // Reads held constantly with a write pending: the run limit lets the write in.
        rk = 0; wk = 0; cyc = 0; saw_idle = 0;
        bus.rd_req        = 1'b1;
        bus.rd_burstbegin = 1'b1;
        bus.rd_size       = SW'(1);
        bus.rd_addr       = AW'('h700);
        exp_rd_q.push_back(mk(1'b0, AW'('h700), '0));
        bus.wr_req        = 1'b1;
        bus.wr_burstbegin = 1'b1;
        bus.wr_size       = SW'(2);
        bus.wr_addr       = AW'('h800);
        bus.wr_data       = DW'('h8000);
        exp_wr_q.push_back(mk(1'b1, AW'('h800), DW'('h8000)));
        while (!(wk == 2 && rk >= 18) && cyc < 200) begin
            @(negedge clk);
            cyc++;
            r_acc = bus.rd_ready;
            w_acc = bus.wr_ready;
            if (rk == 16 && !saw_idle) begin
                chk("t4_idle_after_run", {bus.grant_rd, bus.grant_wr}, 0);
                saw_idle = 1;
            end
            if (w_acc && wk == 0) chk("t4_reads_before_write", rk, 16);
            if (r_acc) rk++;
            if (w_acc) wk++;
            next_cycle();
            if (r_acc) begin
                bus.rd_addr = AW'('h700 + rk);
                exp_rd_q.push_back(mk(1'b0, AW'('h700 + rk), '0));
            end
            if (w_acc) begin
                if (wk == 2) begin
                    bus.wr_req        = 1'b0;
                    bus.wr_burstbegin = 1'b0;
                end else begin
                    bus.wr_burstbegin = 1'b0;
                    bus.wr_size       = SW'(0);
                    bus.wr_data       = DW'('h8001);
                    exp_wr_q.push_back(mk(1'b1, AW'('h800), DW'('h8001)));
                end
            end
        end
        if (cyc >= 200) begin
            checks++;
            errors++;
            $display("FAIL t4_timeout: reads %0d writes %0d after %0d cycles", rk, wk, cyc);
        end
        chk("t4_write_beats", wk, 2);
        bus.rd_req = 1'b0;
        if (exp_rd_q.size() > 0) drop_e = exp_rd_q.pop_back();
        next_cycle();
        next_cycle();

        // Eight-beat burst with five stalled cycles before beat 3.
        k = 0; stall = 0; cyc = 0;
        bus.wr_req        = 1'b1;
        bus.wr_burstbegin = 1'b1;
        bus.wr_size       = SW'(8);
        bus.wr_addr       = AW'('h900);
        bus.wr_data       = DW'('h9000);
        exp_wr_q.push_back(mk(1'b1, AW'('h900), DW'('h9000)));
        while (k < 8 && cyc < 100) begin
            bus.avl_ready = !(k == 2 && stall < 5);
            @(negedge clk);
            cyc++;
            if (!bus.avl_ready) begin
                chk($sformatf("t5_stall%0d_write_req", stall), bus.avl_write_req, 1);
                chk($sformatf("t5_stall%0d_addr", stall), bus.avl_addr, 'h900);
                chk($sformatf("t5_stall%0d_data", stall), bus.avl_wr_data, 'h9002);
                chk($sformatf("t5_stall%0d_wr_ready", stall), bus.wr_ready, 0);
                chk($sformatf("t5_stall%0d_grant_wr", stall), bus.grant_wr, 1);
                stall++;
            end
            w_acc = bus.wr_ready;
            if (w_acc) k++;
            next_cycle();
            if (w_acc && k < 8) begin
                bus.wr_burstbegin = 1'b0;
                bus.wr_size       = SW'(0);
                bus.wr_data       = DW'('h9000 + k);
                exp_wr_q.push_back(mk(1'b1, AW'('h900), DW'('h9000 + k)));
            end
        end
        bus.avl_ready = 1'b1;
        bus.wr_req    = 1'b0;
        @(negedge clk);
        chk("t5_beats", k, 8);
        chk("t5_stalls", stall, 5);
        chk("t5_idle_after", bus.grant_wr, 0);
        next_cycle();

        // Reset asserted after beat 3 of 8 aborts the burst.
        k = 0; cyc = 0;
        bus.wr_req        = 1'b1;
        bus.wr_burstbegin = 1'b1;
        bus.wr_size       = SW'(8);
        bus.wr_addr       = AW'('hb00);
        bus.wr_data       = DW'('hb000);
        exp_wr_q.push_back(mk(1'b1, AW'('hb00), DW'('hb000)));
        while (k < 3 && cyc < 50) begin
            @(negedge clk);
            cyc++;
            w_acc = bus.wr_ready;
            if (w_acc) k++;
            next_cycle();
            if (w_acc && k < 3) begin
                bus.wr_burstbegin = 1'b0;
                bus.wr_size       = SW'(0);
                bus.wr_data       = DW'('hb000 + k);
                exp_wr_q.push_back(mk(1'b1, AW'('hb00), DW'('hb000 + k)));
            end
        end
        chk("t6_beats_before_reset", k, 3);
        bus.wr_burstbegin = 1'b0;
        bus.wr_data       = DW'('hb003);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_write_req", bus.avl_write_req, 0);
        chk("t6_rst_wr_ready", bus.wr_ready, 0);
        chk("t6_rst_grant_wr", bus.grant_wr, 0);
        chk("t6_rst_addr", bus.avl_addr, 0);
        chk("t6_rst_data", bus.avl_wr_data, 0);
        next_cycle();
        bus.wr_req        = 1'b0;
        bus.rd_req        = 1'b1;
        bus.rd_burstbegin = 1'b1;
        bus.rd_size       = SW'(1);
        bus.rd_addr       = AW'('ha00);
        exp_rd_q.push_back(mk(1'b0, AW'('ha00), '0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_idle_state", state, ARB_IDLE);
        chk("t6_idle_read_req", bus.avl_read_req, 0);
        next_cycle();
        @(negedge clk);
        chk("t6_grant_rd", bus.grant_rd, 1);
        chk("t6_rd_ready", bus.rd_ready, 1);
        next_cycle();
        bus.rd_req = 1'b0;
        next_cycle();
        next_cycle();

        chk("sb_rd_left", exp_rd_q.size(), 0);
        chk("sb_wr_left", exp_wr_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
